usart_rx: RTL and testbench

//   Serial receiver, counterpart of the USART transmitter: recovers 8N1 frames
//   (1 start bit low, 8 data bits LSB-first, 1 stop bit high) from Serial_IN.

---
 rtl/usart_rx.sv | 155 +++++++++++++++
 tb/tb_usart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/usart_rx.sv
// usart_rx -- 8N1 serial receiver.
//   Recovers frames (start low, 8 data bits LSB-first, stop high) from an
//   asynchronous line and presents each good byte in parallel with a strobe.
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active-high
//   Serial_IN  in   asynchronous serial line, idles high
//   D          out  [7:0] last good byte, D[0] = first data bit received
//   RX_DONE    out  one-cycle pulse, D updated with a new good byte
//   FRAME_ERR  out  one-cycle pulse, stop bit sampled low
//   RX_BUSY    out  high whenever the receiver is not idle
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, >= 4
//   SYNC_STAGES   synchroniser depth on Serial_IN, >= 2
module usart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Serial_IN,
  output logic [7:0] D,
  output logic       RX_DONE,
  output logic       FRAME_ERR,
  output logic       RX_BUSY
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             d_q, d_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      d_q     <= d_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], Serial_IN};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    d_d     = d_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Re-check the line half a bit in; a short low is treated as noise.
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter was cleared mid start bit, so each wrap lands mid data bit.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving mid stop bit gives half a bit of slack for the next start.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            d_d     = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line must return high before another start is looked for.
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign D         = d_q;
  assign RX_DONE   = done_q;
  assign FRAME_ERR = ferr_q;
  assign RX_BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx -- directed bench for usart_rx at 16 clocks per bit.
module tb_usart_rx;

  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Serial_IN = 1'b1;
  logic [7:0] D;
  logic       RX_DONE;
  logic       FRAME_ERR;
  logic       RX_BUSY;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned done_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  logic [7:0]  d_seen[$];

  usart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Serial_IN(Serial_IN),
    .D        (D),
    .RX_DONE  (RX_DONE),
    .FRAME_ERR(FRAME_ERR),
    .RX_BUSY  (RX_BUSY)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor: every high cycle of a strobe is counted, so a pulse
  // longer than one cycle shows up as an extra count.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RX_DONE) begin
        done_cnt++;
        d_seen.push_back(D);
      end
      if (FRAME_ERR) ferr_cnt++;
      if (RX_DONE && FRAME_ERR) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic v, input int unsigned p);
    Serial_IN = v;
    wait_clk(p);
  endtask

  task automatic send_frame(input logic [7:0] data, input int unsigned p,
                            input logic stop_bit);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    drive_bit(stop_bit, p);
  endtask

  int unsigned done0;
  int unsigned ferr0;

  initial begin
    // 1: reset held with the line toggling
    wait_clk(1);
    for (int i = 0; i < 20; i++) begin
      Serial_IN = ~Serial_IN;
      wait_clk(3);
    end
    check_eq("rst_d", D, 8'h00);
    check_eq("rst_done", RX_DONE, 1'b0);
    check_eq("rst_ferr", FRAME_ERR, 1'b0);
    check_eq("rst_busy", RX_BUSY, 1'b0);
    Serial_IN = 1'b1;
    wait_clk(4);
    RST = 1'b0;
    wait_clk(2 * CPB);

    // 2: single frame A5
    fork
      send_frame(8'hA5, CPB, 1'b1);
      begin
        wait_clk(4 * CPB);
        check_eq("a5_busy_mid", RX_BUSY, 1'b1);
      end
    join
    wait_clk(2 * CPB);
    check_eq("a5_done_cnt", done_cnt, 1);
    check_eq("a5_d", D, 8'hA5);
    check_eq("a5_ferr_cnt", ferr_cnt, 0);
    check_eq("a5_busy_after", RX_BUSY, 1'b0);

    // 1b: reset in the middle of a frame
    done0 = done_cnt;
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB / 2);
    RST = 1'b1;
    #1;
    check_eq("midrst_d", D, 8'h00);
    check_eq("midrst_busy", RX_BUSY, 1'b0);
    Serial_IN = 1'b1;
    wait_clk(3);
    RST = 1'b0;
    wait_clk(20 * CPB);
    check_eq("midrst_no_done", done_cnt, done0);
    check_eq("midrst_d_hold", D, 8'h00);

    // 3: back-to-back frames, no idle gap
    d_seen.delete();
    done0 = done_cnt;
    send_frame(8'h00, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    send_frame(8'h3C, CPB, 1'b1);
    wait_clk(2 * CPB);
    check_eq("b2b_done_cnt", done_cnt - done0, 3);
    check_eq("b2b_q_size", d_seen.size(), 3);
    check_eq("b2b_d0", d_seen[0], 8'h00);
    check_eq("b2b_d1", d_seen[1], 8'hFF);
    check_eq("b2b_d2", d_seen[2], 8'h3C);
    check_eq("b2b_d", D, 8'h3C);

    // 4: start glitch of 5 clocks
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 3 * CPB);
    check_eq("glitch_busy", RX_BUSY, 1'b0);
    check_eq("glitch_done", done_cnt, done0);
    check_eq("glitch_ferr", ferr_cnt, ferr0);
    check_eq("glitch_d", D, 8'h3C);

    // 5: framing error then a long break, then a good frame
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    send_frame(8'h55, CPB, 1'b0);
    drive_bit(1'b0, 40 * CPB);
    check_eq("brk_busy", RX_BUSY, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check_eq("brk_ferr_cnt", ferr_cnt - ferr0, 1);
    check_eq("brk_no_done", done_cnt, done0);
    check_eq("brk_d", D, 8'h3C);
    check_eq("brk_busy_after", RX_BUSY, 1'b0);
    send_frame(8'h81, CPB, 1'b1);
    wait_clk(2 * CPB);
    check_eq("post_brk_done", done_cnt - done0, 1);
    check_eq("post_brk_d", D, 8'h81);

    // 6: baud skew, transmitter at 15 and 17 clocks per bit
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    send_frame(8'hC3, 15, 1'b1);
    drive_bit(1'b1, 3 * CPB);
    check_eq("skew15_done", done_cnt - done0, 1);
    check_eq("skew15_d", D, 8'hC3);
    check_eq("skew15_ferr", ferr_cnt, ferr0);
    drive_bit(1'b1, 0);
    send_frame(8'h81, CPB, 1'b1);
    drive_bit(1'b1, 2 * CPB);
    check_eq("reload_d", D, 8'h81);
    done0 = done_cnt;
    send_frame(8'hC3, 17, 1'b1);
    drive_bit(1'b1, 3 * CPB);
    check_eq("skew17_done", done_cnt - done0, 1);
    check_eq("skew17_d", D, 8'hC3);
    check_eq("skew17_ferr", ferr_cnt, ferr0);

    check_eq("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
